mem_arbiter: RTL and testbench

- Shares the single-ported RAM between the icache and the dcache of one core.
- Sits between the two caches' memory-side ports and the RAM controller.
- Gives the dcache priority and locks the RAM for a whole dcache two-word block, so icache fetches never split a writeback or fill.
- Guarantees icache forward progress with a starvation counter, and reports RAM errors.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter_starve_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side blocks of the core.
//   ramstate_t  : handshake status reported by the RAM controller
//   arb_state_t : grant state of the icache/dcache memory arbiter
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating starvation counter for the icache.
//   CLK, nRST : clock, asynchronous active-low reset
//   en        : icache is waiting this cycle (count up)
//   clr       : icache access completed this cycle (restart from 0)
//   sat       : count has reached LIMIT; the icache must win the next grant
// The force flag is simply the saturated condition: it stays asserted until
// the icache completes, because only a completion clears the count.
module starve_counter #(
    parameter int LIMIT = 8,
    parameter int W     = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic en,
    input  logic clr,
    output logic sat
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LIMIT_V)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign sat = (count_reg == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between the icache and the dcache.
//   CLK, nRST              : clock, asynchronous active-low reset
//   iREN, iaddr            : icache read request and word address
//   iload, iwait           : icache read data / stall (0 only when completing)
//   dREN, dWEN, daddr      : dcache request; daddr[2] selects the block word
//   dstore                 : dcache write data
//   dload, dwait           : dcache read data / stall (0 only when completing)
//   ramREN, ramWEN         : RAM strobes, decoded from the grant state
//   ramaddr, ramstore      : RAM address / write data
//   ramload, ramstate      : RAM read data / handshake status
//   ram_err                : sticky, set by any ERROR cycle while granted
// The dcache has priority and keeps the RAM across both words of a block;
// a starvation counter forces an icache grant at the next IDLE.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);

    arb_state_t state_reg, state_next;
    logic       lock_reg, lock_next;
    logic       ram_err_reg, ram_err_next;
    ramstate_t  ram_st;
    logic       d_req;
    logic       i_done;
    logic       force_i;

    assign ram_st = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;
    assign i_done = (state_reg == IGRANT) && (ram_st == ACCESS);

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (iREN && (state_reg != IGRANT)),
        .clr  (i_done),
        .sat  (force_i)
    );

    // ERROR only counts while a requester owns the RAM.
    assign ram_err_next = ram_err_reg | ((state_reg != IDLE) && (ram_st == ERROR));
    assign ram_err      = ram_err_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg   <= IDLE;
            lock_reg    <= 1'b0;
            ram_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lock_reg    <= lock_next;
            ram_err_reg <= ram_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lock_next  = lock_reg;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iload      = '0;
        dload      = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;

        unique case (state_reg)
            IDLE: begin
                if (force_i && iREN) begin
                    state_next = IGRANT;
                end else if (d_req) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (ram_st == ACCESS) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload = ramload;
                    end
                end
                if (!d_req) begin
                    // Dcache walked away: release the RAM and any lock.
                    lock_next  = 1'b0;
                    state_next = IDLE;
                end else if (ram_st == ACCESS) begin
                    // First block word locks the RAM, second word releases it.
                    lock_next  = ~daddr[2];
                    state_next = (~daddr[2] && d_req) ? DGRANT : IDLE;
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (ram_st == ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    state_next = IDLE;
                end else if (!iREN) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache masters push expected completions,
// a behavioural RAM answers the strobes, and a monitor checks every cycle.
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    logic [31:0] dref    [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    int lat_min = 0, lat_max = 0, err_pct = 0;
    int busy_left = -1;
    bit err_seen = 0;
    bit err_hist = 0;
    bit in_burst = 0;

    mem_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return dref.exists(a) ? dref[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s at %0t", nm, why, $time);
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge CLK);
        #1;
    endtask

    // Behavioural RAM controller: answers strobes with a random number of
    // BUSY (or injected ERROR) cycles before ACCESS.
    always @(negedge CLK) begin
        if (!nRST) begin
            ramstate  = RS_FREE;
            ramload   = '0;
            busy_left = -1;
            err_seen  = 0;
        end else if (ramREN || ramWEN) begin
            if (busy_left < 0) busy_left = int'($urandom_range(lat_max, lat_min));
            if (busy_left == 0) begin
                ramstate = RS_ACCESS;
                if (ramWEN) begin
                    ram_mem[ramaddr] = ramstore;
                    ramload = $urandom;
                end else begin
                    ramload = ram_rd(ramaddr);
                end
                busy_left = -1;
            end else begin
                if (err_pct > 0 && int'($urandom_range(99, 0)) < err_pct) begin
                    ramstate = RS_ERROR;
                    err_seen = 1;
                end else begin
                    ramstate = RS_BUSY;
                end
                ramload   = $urandom;
                busy_left = busy_left - 1;
            end
        end else begin
            ramstate  = RS_FREE;
            ramload   = $urandom;
            busy_left = -1;
        end
    end

    // Monitor: pops the scoreboard on every completion, checks idle outputs.
    initial begin
        exp_t e;
        forever begin
            step();
            if (!nRST) begin
                err_hist = 0;
                in_burst = 0;
            end else begin
                if (ramREN && ramWEN) fail_now("strobe_excl", "ramREN and ramWEN both high");
                if (iwait) begin
                    chk("iload_idle", iload, 32'h0);
                end else begin
                    if (ramstate != RS_ACCESS) fail_now("i_early", "iwait low without ACCESS");
                    if (in_burst) fail_now("i_in_burst", "icache completed inside a dcache block");
                    if (iq.size() == 0) begin
                        fail_now("i_unexpected", "icache completion with nothing pending");
                    end else begin
                        e = iq.pop_front();
                        chk("iload", iload, e.data);
                        chk("i_ramaddr", ramaddr, e.addr);
                        chk("i_strobes", 32'({ramWEN, ramREN}), 32'h1);
                    end
                end
                if (dwait) begin
                    chk("dload_idle", dload, 32'h0);
                end else begin
                    if (ramstate != RS_ACCESS) fail_now("d_early", "dwait low without ACCESS");
                    if (dq.size() == 0) begin
                        fail_now("d_unexpected", "dcache completion with nothing pending");
                    end else begin
                        e = dq.pop_front();
                        chk("d_ramaddr", ramaddr, e.addr);
                        if (e.wr) begin
                            chk("d_wr_strobes", 32'({ramWEN, ramREN}), 32'h2);
                            chk("ramstore", ramstore, e.data);
                        end else begin
                            chk("d_rd_strobes", 32'({ramWEN, ramREN}), 32'h1);
                            chk("dload", dload, e.data);
                        end
                        in_burst = ~e.addr[2];
                    end
                end
                chk("ram_err", 32'(ram_err), 32'(err_hist));
                err_hist = err_seen;
            end
        end
    end

    task automatic wait_done(input bit is_i, input int bound, output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < bound) begin
            step();
            n++;
            if (nRST && (is_i ? !iwait : !dwait)) ok = 1;
        end
    endtask

    task automatic i_fetch(input logic [31:0] a, input int bound);
        bit ok;
        iaddr = a;
        iREN  = 1'b1;
        iq.push_back('{a, init_word(a), 1'b0});
        wait_done(1'b1, bound, ok);
        if (!ok) begin
            $display("FAIL i_timeout: addr %h got no completion within %0d cycles", a, bound);
            vectors++;
            miscompares++;
            iq.delete(iq.size() - 1);
        end
        drive_edge();
        iREN = 1'b0;
    endtask

    task automatic d_block(input logic [31:0] base, input bit wr, input bit both, input int bound);
        bit ok;
        logic [31:0] a;
        for (int w = 0; w < 2; w++) begin
            a     = base + 32'(w * 4);
            daddr = a;
            if (wr) begin
                dstore = $urandom;
                dWEN   = 1'b1;
                dREN   = both;
                dref[a] = dstore;
                dq.push_back('{a, dstore, 1'b1});
            end else begin
                dWEN = 1'b0;
                dREN = 1'b1;
                dq.push_back('{a, ref_rd(a), 1'b0});
            end
            wait_done(1'b0, bound, ok);
            if (!ok) begin
                $display("FAIL d_timeout: addr %h got no completion within %0d cycles", a, bound);
                vectors++;
                miscompares++;
                dq.delete(dq.size() - 1);
                break;
            end
            drive_edge();
        end
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;

        // Reset values
        step();
        chk("rst_strobes", 32'({ramWEN, ramREN}), 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_loads", iload | dload, 32'h0);
        chk("rst_waits", 32'({iwait, dwait}), 32'h3);
        chk("rst_ram_err", 32'(ram_err), 32'h0);
        #2 nRST = 1'b1;

        // Single icache read, RAM answers after two BUSY cycles
        lat_min = 2; lat_max = 2; err_pct = 0;
        drive_edge();
        iaddr = 32'h40; iREN = 1'b1;
        iq.push_back('{32'h40, init_word(32'h40), 1'b0});
        step(); chk("t1_c0_strobes", 32'({ramWEN, ramREN}), 32'h0);
        step(); chk("t1_c1_strobes", 32'({ramWEN, ramREN}), 32'h1);
                chk("t1_c1_ramaddr", ramaddr, 32'h40);
        step(); chk("t1_c2_iwait", 32'(iwait), 32'h1);
        step(); chk("t1_c3_iwait", 32'(iwait), 32'h0);
        drive_edge(); iREN = 1'b0;
        step(); chk("t1_c4_idle", 32'({ramWEN, ramREN}), 32'h0);

        // dREN and dWEN together: write wins
        lat_min = 0; lat_max = 0;
        drive_edge();
        d_block(32'h1200, 1'b1, 1'b1, 20);

        // Dcache write block and icache request raised together
        fork
            d_block(32'h1000, 1'b1, 1'b0, 20);
            i_fetch(32'h48, 20);
        join

        // ERROR during a dcache read block keeps the handshake waiting
        lat_min = 1; lat_max = 1; err_pct = 100;
        d_block(32'h1300, 1'b0, 1'b0, 20);
        err_pct = 0; lat_min = 0; lat_max = 0;
        repeat (2) step();
        chk("err_sticky", 32'(ram_err), 32'h1);

        // Continuous dcache blocks must not starve the icache
        fork
            begin
                for (int b = 0; b < 8; b++) d_block(32'h1400 + 32'(b * 8), 1'(b % 2), 1'b0, 40);
            end
            begin
                drive_edge();
                i_fetch(32'h80, 14);
            end
        join

        // Reset in the middle of a locked dcache block
        drive_edge();
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h1500;
        dq.push_back('{32'h1500, ref_rd(32'h1500), 1'b0});
        wait_done(1'b0, 10, ok);
        if (!ok) fail_now("t6_first_word", "first block word never completed");
        drive_edge();
        lat_min = 6; lat_max = 6;
        daddr = 32'h1504;
        step();
        chk("t6_word2_strobes", 32'({ramWEN, ramREN}), 32'h1);
        chk("t6_word2_addr", ramaddr, 32'h1504);
        #2 nRST = 1'b0;
        #1;
        chk("t6_async_strobes", 32'({ramWEN, ramREN}), 32'h0);
        chk("t6_async_waits", 32'({iwait, dwait}), 32'h3);
        chk("t6_async_err", 32'(ram_err), 32'h0);
        dREN = 1'b0;
        iq.delete(); dq.delete();
        lat_min = 0; lat_max = 0;
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;
        drive_edge();
        i_fetch(32'h44, 3);

        // Randomised traffic from both caches
        lat_min = 0; lat_max = 3; err_pct = 10;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    i_fetch(32'($urandom_range(255, 0)) * 32'd4, 80);
                    repeat ($urandom_range(3, 0)) drive_edge();
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    d_block(32'h1000 + 32'($urandom_range(31, 0)) * 32'd8,
                            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 80);
                    repeat ($urandom_range(3, 0)) drive_edge();
                end
            end
        join
        err_pct = 0;
        repeat (4) step();

        chk("iq_drained", 32'(iq.size()), 32'h0);
        chk("dq_drained", 32'(dq.size()), 32'h0);
        foreach (dref[a]) chk("mem_contents", ram_rd(a), dref[a]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
